// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_mp multi-port register file.
package regfile_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NR_DEF    = 2;
  localparam int unsigned NW_DEF    = 2;
  localparam int unsigned MAX_PORTS = 32;

  // Index of the highest set bit; higher write ports win a collision.
  function automatic int unsigned win_port(input logic [MAX_PORTS-1:0] hit);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (hit[i]) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets, write clears, reserve wins a tie.
// REGFILE_BYPASS_EN selects post-update (defined) or pre-update busy lookups.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter int unsigned NR       = NR_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREGS-1:0]   wr_clr,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  input  logic [NR*AW-1:0]   ra,
  input  logic [NR-1:0]      ra_ok,
  output logic [NR-1:0]      rd_busy_c,
  output logic               busy_any
);

  localparam int unsigned NSPAN = 2 ** AW;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] rsv_set;
  logic             rsv_ok;

  if (NREGS == NSPAN) begin : g_rsv_full
    assign rsv_ok = 1'b1;
  end else begin : g_rsv_part
    assign rsv_ok = (32'(rsv_addr) < NREGS);
  end

  always_comb begin
    rsv_set = '0;
    if (rsv_en && rsv_ok) rsv_set[rsv_addr] = 1'b1;
    busy_nxt = (busy & ~wr_clr) | rsv_set;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_any <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_any <= |busy_nxt;
    end
  end

  always_comb begin
    rd_busy_c = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (ra_ok[k]) begin
`ifdef REGFILE_BYPASS_EN
        rd_busy_c[k] = busy_nxt[ra[k*AW +: AW]];
`else
        rd_busy_c[k] = busy[ra[k*AW +: AW]];
`endif
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered reads and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes (and busy updates) to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter int unsigned NR       = NR_DEF,
  parameter int unsigned NW       = NW_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR-1:0]      rd_en,
  input  logic [NR*AW-1:0]   ra,
  output logic [NR*DW-1:0]   rd,
  output logic [NR-1:0]      rd_valid,
  output logic [NR-1:0]      rd_busy,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*AW-1:0]   wa,
  input  logic [NW*DW-1:0]   wd,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  output logic               busy_any
);

  localparam int unsigned NSPAN = 2 ** AW;

  logic [DW-1:0]        regs     [NREGS];
  logic [DW-1:0]        regs_nxt [NREGS];
  logic [NREGS-1:0]     wr_clr;
  logic [MAX_PORTS-1:0] hit;
  logic [NR*DW-1:0]     rd_data_c;
  logic [NR-1:0]        rd_busy_c;
  logic [NR-1:0]        ra_ok;

  for (genvar k = 0; k < NR; k++) begin : g_ra_ok
    if (NREGS == NSPAN) begin : g_full
      assign ra_ok[k] = 1'b1;
    end else begin : g_part
      assign ra_ok[k] = (32'(ra[k*AW +: AW]) < NREGS);
    end
  end

  // Next storage state: highest matching write port wins; register 0 may be hardwired.
  always_comb begin
    hit    = '0;
    wr_clr = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      regs_nxt[r] = regs[r];
      hit = '0;
      for (int unsigned j = 0; j < NW; j++) begin
        hit[j] = wr_en[j] && (wa[j*AW +: AW] == AW'(r));
      end
      if ((|hit) && !((ZERO_REG != 0) && (r == 0))) begin
        regs_nxt[r] = wd[win_port(hit)*DW +: DW];
        wr_clr[r]   = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (ra_ok[k]) begin
`ifdef REGFILE_BYPASS_EN
        rd_data_c[k*DW +: DW] = regs_nxt[ra[k*AW +: AW]];
`else
        rd_data_c[k*DW +: DW] = regs[ra[k*AW +: AW]];
`endif
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .NR       (NR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wr_clr    (wr_clr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .ra        (ra),
    .ra_ok     (ra_ok),
    .rd_busy_c (rd_busy_c),
    .busy_any  (busy_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
      rd       <= '0;
      rd_valid <= '0;
      rd_busy  <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= regs_nxt[r];
      rd_valid <= rd_en;
      for (int unsigned k = 0; k < NR; k++) begin
        if (rd_en[k]) begin
          rd[k*DW +: DW] <= rd_data_c[k*DW +: DW];
          rd_busy[k]     <= rd_busy_c[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default 32x32, 2R/2W, ZERO_REG=1).
module tb_regfile_mp;

  localparam int unsigned DW = 32, NREGS = 32, AW = 5, NR = 2, NW = 2;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP5   = 32'h0000_A5A5;
  localparam logic [31:0] BYP11D = 32'h0000_0123;
  localparam logic        BYP11B = 1'b1;
`else
  localparam logic [31:0] BYP5   = 32'h0000_0001;
  localparam logic [31:0] BYP11D = 32'h0000_0099;
  localparam logic        BYP11B = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rd_valid;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] wd;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             busy_any;

  regfile_mp #(
    .DW(DW), .NREGS(NREGS), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .ra(ra), .rd(rd),
    .rd_valid(rd_valid), .rd_busy(rd_busy), .wr_en(wr_en), .wa(wa),
    .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd0, rd1;
    logic [1:0]  valid, busy;
    logic        any;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [1:0]  rd_en;
    logic [4:0]  ra0, ra1;
    logic [1:0]  wr_en;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    exp_t        e;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl [17];

  function automatic vec_t mk(
    input logic r, input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
    input logic [1:0] we, input logic [4:0] w0, input logic [31:0] d0,
    input logic [4:0] w1, input logic [31:0] d1,
    input logic rv, input logic [4:0] radr,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] ev,
    input logic [1:0] eb, input logic ea);
    vec_t v;
    v.rst = r; v.rd_en = re; v.ra0 = a0; v.ra1 = a1;
    v.wr_en = we; v.wa0 = w0; v.wd0 = d0; v.wa1 = w1; v.wd1 = d1;
    v.rsv_en = rv; v.rsv_addr = radr;
    v.e.rd0 = e0; v.e.rd1 = e1; v.e.valid = ev; v.e.busy = eb; v.e.any = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    rst = v.rst; rd_en = v.rd_en; ra = {v.ra1, v.ra0};
    wr_en = v.wr_en; wa = {v.wa1, v.wa0}; wd = {v.wd1, v.wd0};
    rsv_en = v.rsv_en; rsv_addr = v.rsv_addr;
    q.push_back(v.e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk($sformatf("%s.rd0", tag), rd[31:0], e.rd0);
    chk($sformatf("%s.rd1", tag), rd[63:32], e.rd1);
    chk($sformatf("%s.rd_valid", tag), 32'(rd_valid), 32'(e.valid));
    chk($sformatf("%s.rd_busy", tag), 32'(rd_busy), 32'(e.busy));
    chk($sformatf("%s.busy_any", tag), 32'(busy_any), 32'(e.any));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table, run from a freshly reset file
    tbl[0]  = mk(0, 2'b00, 0, 0, 2'b11, 5, 32'hDEADBEEF, 3, 32'h1, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0);
    tbl[1]  = mk(0, 2'b11, 5, 3, 2'b00, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h1, 2'b11, 2'b00, 0);
    tbl[2]  = mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h1, 2'b00, 2'b00, 0);
    tbl[3]  = mk(0, 2'b00, 0, 0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 32'hDEADBEEF, 32'h1, 2'b00, 2'b00, 0);
    tbl[4]  = mk(0, 2'b11, 7, 5, 2'b00, 0, 0, 0, 0, 0, 0, 32'h22, 32'hDEADBEEF, 2'b11, 2'b00, 0);
    tbl[5]  = mk(0, 2'b10, 0, 3, 2'b01, 3, 32'hA5A5, 0, 0, 0, 0, 32'h22, BYP5, 2'b10, 2'b00, 0);
    tbl[6]  = mk(0, 2'b01, 3, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'hA5A5, BYP5, 2'b01, 2'b00, 0);
    tbl[7]  = mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 9, 32'hA5A5, BYP5, 2'b00, 2'b00, 1);
    tbl[8]  = mk(0, 2'b11, 9, 5, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 2'b11, 2'b01, 1);
    tbl[9]  = mk(0, 2'b00, 0, 0, 2'b10, 0, 0, 9, 32'h99, 0, 0, 32'h0, 32'hDEADBEEF, 2'b00, 2'b01, 0);
    tbl[10] = mk(0, 2'b01, 9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h99, 32'hDEADBEEF, 2'b01, 2'b00, 0);
    tbl[11] = mk(0, 2'b10, 0, 9, 2'b01, 9, 32'h123, 0, 0, 1, 9, 32'h99, BYP11D, 2'b10, {BYP11B, 1'b0}, 1);
    tbl[12] = mk(0, 2'b01, 9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h123, BYP11D, 2'b01, {BYP11B, 1'b1}, 1);
    tbl[13] = mk(0, 2'b10, 0, 0, 2'b01, 0, 32'hFFFF, 0, 0, 1, 0, 32'h123, 32'h0, 2'b10, 2'b01, 1);
    tbl[14] = mk(0, 2'b11, 0, 9, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 32'h123, 2'b11, 2'b10, 1);
    tbl[15] = mk(0, 2'b01, 9, 0, 2'b00, 0, 0, 0, 0, 1, 9, 32'h123, 32'h123, 2'b01, 2'b11, 1);
    tbl[16] = mk(0, 2'b10, 0, 10, 2'b01, 9, 32'hAA, 0, 0, 0, 0, 32'h123, 32'h0, 2'b10, 2'b01, 0);

    // Initial reset clears all outputs
    step(mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0), "reset0");

    // Fill every register with nonzero data and reserve as we go
    for (int i = 0; i < 16; i++) begin
      step(mk(0, 2'b00, 0, 0, 2'b11, 5'(2*i), 32'(32'h1000 + 2*i), 5'(2*i+1), 32'(32'h1000 + 2*i + 1),
              1, 5'(2*i), 32'h0, 32'h0, 2'b00, 2'b00, (i > 0)), $sformatf("fill%0d", i));
    end

    // Reset overrides same-cycle reads, writes and reserves
    step(mk(1, 2'b11, 1, 2, 2'b11, 1, 32'hBAD1, 2, 32'hBAD2, 1, 4, 32'h0, 32'h0, 2'b00, 2'b00, 0), "reset1");

    for (int i = 0; i < 16; i++) begin
      step(mk(0, 2'b11, 5'(2*i), 5'(2*i+1), 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b11, 2'b00, 0),
           $sformatf("rdclr%0d", i));
    end

    for (int t = 0; t < 17; t++) step(tbl[t], $sformatf("t%0d", t));

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file that succeeds the fixed 2-read/2-write, 32×32 register bank in the CPU32 datapath. Width, depth and port counts are configurable. Reads are registered. Write collisions are resolved deterministically. A per-register busy scoreboard lets the issue stage detect read-after-write hazards on long-latency results. The block sits between decode/issue (read and reserve) and writeback (write).

## Interface
Parameters:
- DW, 32, data width in bits
- NREGS, 32, number of registers (≥2)
- AW, $clog2(NREGS), register address width
- NR, 2, number of read ports (≥1)
- NW, 2, number of write ports (≥1)
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy

Ports (vectors flattened; port k occupies slice [k*W +: W]):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_en  in  NR  read request per read port
- ra  in  NR*AW  read addresses
- rd  out  NR*DW  registered read data
- rd_valid  out  NR  1 in the cycle after an accepted rd_en
- rd_busy  out  NR  registered busy flag of the address read
- wr_en  in  NW  write enable per write port
- wa  in  NW*AW  write addresses
- wd  in  NW*DW  write data
- rsv_en  in  1  reserve: mark rsv_addr busy (pending producer)
- rsv_addr  in  AW  register to reserve
- busy_any  out  1  OR of all busy bits, registered

## Operation
- Reset (rst=1 at edge): all registers 0, all busy bits 0; rd=0, rd_valid=0, rd_busy=0, busy_any=0. rst overrides every other input that cycle.
- Read: if rd_en[k] is 1 at edge N, then rd[k] and rd_busy[k] load at edge N and are visible in cycle N+1. rd_valid[k]=1 in cycle N+1.
- If rd_en[k]=0: rd[k] and rd_busy[k] hold their previous values; rd_valid[k]=0.
- Write: wr_en[j] at edge N updates regs[wa[j]] with wd[j].
- Collision: when multiple write ports target the same address, the highest port index wins.
- Addresses ≥ NREGS: writes are ignored; reads return 0 with busy 0.
- Scoreboard:
  - A write to address a clears busy[a].
  - rsv_en sets busy[rsv_addr].
  - Reserve and write to the same address in the same cycle: the reserve wins and busy ends at 1, because it marks a newer producer.
  - Reserving an already-busy register leaves it busy. No counting; one outstanding producer per register.
- ZERO_REG=1: register 0 is never written or reserved; reads return 0 with busy 0.
- busy_any is updated every edge from the post-update busy vector.

## Timing
- Read latency: 1 cycle, address to data.
- Write latency: the write is visible to a read issued in the next cycle.
- Same-cycle read/write of one address depends on REGFILE_BYPASS_EN (see Configuration).
- No backpressure; every port accepts one request per cycle.
- Deasserting rst mid-stream: the first request after rst falls behaves as if issued from the reset state.

## Configuration
- REGFILE_BYPASS_EN defined: a read at edge N of an address written at edge N returns the new data (winning write port). rd_busy reflects the post-update scoreboard, so the write-clear and reserve-set rules apply.
- REGFILE_BYPASS_EN undefined: the same-cycle read returns the pre-write data and the pre-update busy bit. Storage and timing are otherwise identical.

## Structure
- Shared package regfile_pkg holds:
  - default parameter constants (DW, NREGS, NR, NW)
  - helper function for the write-collision priority select (index of the highest active matching port)
- One natural sub-module: regfile_scoreboard. It holds the NREGS-bit busy vector, the reserve/clear logic, busy_any, and the NR combinational busy lookups. Storage and read ports stay in regfile_mp.

## Test plan
- Reset: write all registers to nonzero values, assert rst for one cycle, then read addresses 0..NREGS-1 → every rd=0, rd_busy=0, busy_any=0.
- Basic R/W: write 0xDEADBEEF to r5, read r5 next cycle → rd=0xDEADBEEF one cycle later with rd_valid=1. Deassert rd_en → rd holds its value and rd_valid=0.
- Collision: wr_en=2'b11, both ports to r7, wd0=0x11, wd1=0x22 → r7 reads 0x22.
- Bypass: write 0xA5A5 to r3 and read r3 in the same cycle (old value 0x1) → rd=0xA5A5 with the macro defined, 0x1 without it.
- Scoreboard:
  - rsv r9, then read r9 → rd_busy=1 and busy_any=1.
  - Write r9 → busy clears.
  - Reserve and write r9 in the same cycle → busy stays 1.
- ZERO_REG: write 0xFFFF to r0 and rsv r0, then read r0 → rd=0, rd_busy=0, busy_any unchanged.
